// File: rtl/qam_demap_pkg.sv
// Shared definitions for the QAM demapper symbol-FIFO sequencer:
// state encoding and the default symbol width (16-QAM).
package qam_demap_pkg;

  // Default bits per demapped symbol; must stay even so it splits into I/Q.
  localparam int QAM_SYM_BITS = 4;

  // Sequencer phases; the encoding is visible on debug taps, so keep it fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RECV  = 2'b01,
    ST_READY = 2'b10,
    ST_DRAIN = 2'b11
  } seq_state_t;

endpackage : qam_demap_pkg

// File: rtl/qam_gray2bin.sv
// Combinational Gray-to-binary converter for one I or Q half of a
// demapped symbol. Used only when QAM_GRAY_DECODE_EN is defined.
module qam_gray2bin
  import qam_demap_pkg::*;
#(
  parameter int W = QAM_SYM_BITS / 2
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above its position.
  always_comb begin
    bin = '0;
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule : qam_gray2bin

// File: rtl/qam_demap_sequencer.sv
// Sequences the demapper symbol FIFO through receive, ready, drain and
// complete phases: counts a fixed-length frame into the FIFO, flags it to
// the host, drains it over valid/ready, then re-arms for the next frame.
// Optional feature: define QAM_GRAY_DECODE_EN to Gray-decode the I and Q
// halves of each symbol ahead of the FIFO write-data register.
module qam_demap_sequencer
  import qam_demap_pkg::*;
#(
  parameter int SYM_BITS  = QAM_SYM_BITS,
  parameter int FRAME_LEN = 64,
  parameter int CNT_W     = 8
) (
  input  logic                dclk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sym_valid,
  input  logic [SYM_BITS-1:0] sym_data,
  output logic                fifo_wr_en,
  output logic [SYM_BITS-1:0] fifo_wdata,
  input  logic                fifo_full,
  output logic                fifo_rd_en,
  input  logic [SYM_BITS-1:0] fifo_rdata,
  input  logic                fifo_empty,
  output logic                fifo_clr,
  output logic                host_valid,
  output logic [SYM_BITS-1:0] host_data,
  input  logic                host_ready,
  output logic                available,
  output logic                complete,
  output logic [CNT_W-1:0]    overflow_cnt,
  output logic [CNT_W-1:0]    frame_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  seq_state_t          state, state_nxt;
  logic [CNT_W-1:0]    sym_cnt;
  logic                rd_inflight;
  logic                sym_accept;
  logic                sym_drop;
  logic                rd_fire;
  logic                drain_done;
  logic                host_take;
  logic [SYM_BITS-1:0] wdata_dec;

`ifdef QAM_GRAY_DECODE_EN
  localparam int HALF = SYM_BITS / 2;

  qam_gray2bin #(.W(HALF)) u_gray_i (
    .gray (sym_data[SYM_BITS-1:HALF]),
    .bin  (wdata_dec[SYM_BITS-1:HALF])
  );

  qam_gray2bin #(.W(HALF)) u_gray_q (
    .gray (sym_data[HALF-1:0]),
    .bin  (wdata_dec[HALF-1:0])
  );
`else
  assign wdata_dec = sym_data;
`endif

  assign host_take  = host_valid && host_ready;
  assign fifo_rd_en = rd_fire;
  assign available  = (state == ST_READY) || (state == ST_DRAIN);

  // Next-state, symbol accept/drop and FIFO read decisions.
  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    sym_accept = 1'b0;
    sym_drop   = 1'b0;
    rd_fire    = 1'b0;
    drain_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RECV;
      end
      ST_RECV: begin
        sym_accept = sym_valid && !fifo_full;
        sym_drop   = sym_valid && fifo_full;
        // A full FIFO closes the frame short; the last accepted write still lands.
        if ((sym_accept && sym_cnt == LAST_IDX) || fifo_full) state_nxt = ST_READY;
      end
      ST_READY: begin
        sym_drop = sym_valid;
        if (host_ready) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        sym_drop   = sym_valid;
        // One read at a time keeps the single output register from being overrun.
        rd_fire    = !fifo_empty && (!host_valid || host_take) && !rd_inflight;
        drain_done = fifo_empty && !rd_inflight && !host_valid;
        if (drain_done) state_nxt = ST_RECV;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Dropping enable abandons the frame from any phase.
    if (!enable) begin
      state_nxt  = ST_IDLE;
      sym_accept = 1'b0;
      rd_fire    = 1'b0;
      drain_done = 1'b0;
    end
  end

  // State register and phase-boundary strobes.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge dclk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      fifo_clr    <= 1'b1;
      complete    <= 1'b0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_nxt;
      fifo_clr    <= (state_nxt == ST_IDLE) && (state != ST_IDLE);
      complete    <= drain_done;
      rd_inflight <= rd_fire;
    end
  end

  // Registered FIFO write port, one cycle behind the accepted symbol.
  always_ff @(posedge dclk) begin
    if (!reset_n) begin
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_wr_en <= sym_accept;
      if (sym_accept) fifo_wdata <= wdata_dec;
    end
  end

  // Frame symbol counter, saturating drop counter and wrapping frame counter.
  always_ff @(posedge dclk) begin
    if (!reset_n) begin
      sym_cnt      <= '0;
      overflow_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      if (sym_accept)                           sym_cnt <= sym_cnt + CNT_W'(1);
      else if (state == ST_IDLE || drain_done)  sym_cnt <= '0;
      if (sym_drop && overflow_cnt != '1)       overflow_cnt <= overflow_cnt + CNT_W'(1);
      if (drain_done)                           frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Host output register: captures read data, holds it until accepted.
  always_ff @(posedge dclk) begin
    if (!reset_n) begin
      host_valid <= 1'b0;
      host_data  <= '0;
    end else if (!enable || state != ST_DRAIN) begin
      host_valid <= 1'b0;
    end else if (rd_inflight) begin
      host_valid <= 1'b1;
      host_data  <= fifo_rdata;
    end else if (host_take) begin
      host_valid <= 1'b0;
    end
  end

endmodule : qam_demap_sequencer

// File: tb/tb_qam_demap_sequencer.sv
// Directed bench for qam_demap_sequencer with FRAME_LEN=4, SYM_BITS=4.
// A small FIFO model stands in for the dual-port FIFO.
module tb_qam_demap_sequencer;

  localparam int SB = 4;
  localparam int CW = 8;

  logic          dclk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          sym_valid;
  logic [SB-1:0] sym_data;
  logic          fifo_wr_en;
  logic [SB-1:0] fifo_wdata;
  logic          fifo_full;
  logic          fifo_rd_en;
  logic [SB-1:0] fifo_rdata = '0;
  logic          fifo_empty;
  logic          fifo_clr;
  logic          host_valid;
  logic [SB-1:0] host_data;
  logic          host_ready;
  logic          available;
  logic          complete;
  logic [CW-1:0] overflow_cnt;
  logic [CW-1:0] frame_cnt;

  logic          full_force;
  logic [SB-1:0] fmem [0:15];
  logic [3:0]    wp = '0;
  logic [3:0]    rp = '0;
  logic [4:0]    fcount = '0;

  int vectors = 0;
  int miscompares = 0;

  qam_demap_sequencer #(.SYM_BITS(SB), .FRAME_LEN(4), .CNT_W(CW)) dut (
    .dclk         (dclk),
    .reset_n      (reset_n),
    .enable       (enable),
    .sym_valid    (sym_valid),
    .sym_data     (sym_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wdata   (fifo_wdata),
    .fifo_full    (fifo_full),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rdata   (fifo_rdata),
    .fifo_empty   (fifo_empty),
    .fifo_clr     (fifo_clr),
    .host_valid   (host_valid),
    .host_data    (host_data),
    .host_ready   (host_ready),
    .available    (available),
    .complete     (complete),
    .overflow_cnt (overflow_cnt),
    .frame_cnt    (frame_cnt)
  );

  always #5 dclk = ~dclk;

  // FIFO model: registered read data, clear has priority.
  always @(posedge dclk) begin
    if (fifo_clr) begin
      wp     <= '0;
      rp     <= '0;
      fcount <= '0;
    end else begin
      if (fifo_wr_en) begin
        fmem[wp] <= fifo_wdata;
        wp       <= wp + 4'd1;
      end
      if (fifo_rd_en) begin
        fifo_rdata <= fmem[rp];
        rp         <= rp + 4'd1;
      end
      fcount <= fcount + 5'(fifo_wr_en) - 5'(fifo_rd_en);
    end
  end

  assign fifo_empty = (fcount == 5'd0);
  assign fifo_full  = full_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge dclk);
    #1;
  endtask

  // Hand-written expected write data for a 4-bit symbol.
  function automatic logic [SB-1:0] exp_wdata(input logic [SB-1:0] s);
`ifdef QAM_GRAY_DECODE_EN
    return {s[3], s[3] ^ s[2], s[1], s[1] ^ s[0]};
`else
    return s;
`endif
  endfunction

  initial begin
    int acc;
    int cpl;
    logic          held_v;
    logic [SB-1:0] held;

    reset_n    = 1'b0;
    enable     = 1'b0;
    sym_valid  = 1'b0;
    sym_data   = '0;
    host_ready = 1'b0;
    full_force = 1'b0;
    step();
    step();

    // Reset state
    check("rst_clr",      fifo_clr,     1);
    check("rst_wr_en",    fifo_wr_en,   0);
    check("rst_rd_en",    fifo_rd_en,   0);
    check("rst_hv",       host_valid,   0);
    check("rst_hdata",    host_data,    0);
    check("rst_avail",    available,    0);
    check("rst_complete", complete,     0);
    check("rst_ovf",      overflow_cnt, 0);
    check("rst_frames",   frame_cnt,    0);
    reset_n = 1'b1;
    step();
    check("idle_clr_off", fifo_clr, 0);

    // Full frame: 1,2,3,4 back to back
    enable = 1'b1;
    step();
    check("recv_wr_idle", fifo_wr_en, 0);
    for (int i = 0; i < 4; i++) begin
      sym_valid = 1'b1;
      sym_data  = SB'(i + 1);
      step();
      check("frame_wr_en",  fifo_wr_en, 1);
      check("frame_wdata",  fifo_wdata, exp_wdata(SB'(i + 1)));
      check("frame_avail",  available,  (i == 3) ? 1 : 0);
    end
    sym_valid = 1'b0;
    step();
    check("frame_wr_off",  fifo_wr_en, 0);
    check("ready_avail",   available,  1);
    check("ready_frames",  frame_cnt,  0);
    check("fifo_level",    fcount,     4);

    // Drain with host_ready toggling every other cycle
    acc    = 0;
    cpl    = 0;
    held_v = 1'b0;
    held   = '0;
    for (int c = 0; c < 40 && cpl == 0; c++) begin
      host_ready = (c % 2 == 0);
      if (held_v) check("drain_hold", {host_valid, host_data}, {1'b1, held});
      if (host_valid && host_ready) begin
        check("drain_data", host_data, exp_wdata(SB'(acc + 1)));
        acc++;
      end
      held_v = host_valid && !host_ready;
      held   = host_data;
      step();
      if (complete) cpl++;
    end
    host_ready = 1'b0;
    check("drain_complete",  cpl,       1);
    check("drain_count",     acc,       4);
    check("drain_frames",    frame_cnt, 1);
    check("drain_avail_off", available, 0);
    step();
    check("complete_pulse",  complete,  0);

    // Overflow: two writes, then FIFO full with three more symbols
    check("ovf_start", overflow_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      full_force = (i >= 2);
      sym_valid  = 1'b1;
      sym_data   = SB'(i + 5);
      step();
      check("ovf_wr_en", fifo_wr_en, (i < 2) ? 1 : 0);
      if (i < 2) check("ovf_wdata", fifo_wdata, exp_wdata(SB'(i + 5)));
    end
    sym_valid = 1'b0;
    step();
    check("ovf_ready", available,    1);
    check("ovf_count", overflow_cnt, 3);
    check("ovf_level", fcount,       2);
    full_force = 1'b0;

    // Abort mid-drain with host_valid high
    host_ready = 1'b1;
    step();
    host_ready = 1'b0;
    for (int c = 0; c < 10 && !host_valid; c++) step();
    check("abort_hv_pre", host_valid, 1);
    check("abort_hdata",  host_data,  exp_wdata(SB'(5)));
    enable = 1'b0;
    step();
    check("abort_hv",    host_valid, 0);
    check("abort_clr",   fifo_clr,   1);
    check("abort_avail", available,  0);
    step();
    check("abort_clr_pulse", fifo_clr, 0);

    // Reset mid-RECV after two symbols
    enable = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      sym_valid = 1'b1;
      sym_data  = SB'(10 + i);
      step();
    end
    sym_valid = 1'b0;
    reset_n   = 1'b0;
    step();
    check("mrst_wr_en",    fifo_wr_en,   0);
    check("mrst_clr",      fifo_clr,     1);
    check("mrst_hv",       host_valid,   0);
    check("mrst_hdata",    host_data,    0);
    check("mrst_avail",    available,    0);
    check("mrst_complete", complete,     0);
    check("mrst_ovf",      overflow_cnt, 0);
    check("mrst_frames",   frame_cnt,    1'b0);
    reset_n = 1'b1;
    step();

    // A fresh frame needs all four symbols, proving the count restarted;
    // its first symbol also exercises the Gray vector 4'b1110.
    for (int i = 0; i < 4; i++) begin
      sym_valid = 1'b1;
      sym_data  = (i == 0) ? 4'b1110 : SB'(i);
      step();
      check("post_rst_avail", available, (i == 3) ? 1 : 0);
      if (i == 0) begin
`ifdef QAM_GRAY_DECODE_EN
        check("gray_wdata", fifo_wdata, 4'b1011);
`else
        check("pass_wdata", fifo_wdata, 4'b1110);
`endif
      end
    end
    sym_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_qam_demap_sequencer
